// File: rtl/gates7_pkg.sv
// Shared op codes and FSM encodings for the bit-serial gate sequencer.
package gates7_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gates7_dataflow.sv
// Single-bit logic unit: every gate function of (a, b), indexed by op code.
module gates7_dataflow (
  input  logic       a_i,
  input  logic       b_i,
  output logic [6:0] y_o
);
  assign y_o[0] = a_i & b_i;
  assign y_o[1] = a_i | b_i;
  assign y_o[2] = ~a_i;
  assign y_o[3] = ~(a_i & b_i);
  assign y_o[4] = ~(a_i | b_i);
  assign y_o[5] = a_i ^ b_i;
  assign y_o[6] = ~(a_i ^ b_i);
endmodule

// File: rtl/gates7_seq.sv
// Two-port round-robin arbiter feeding word operands LSB-first through one
// shared gate unit; the result word is returned over valid/ready.
module gates7_seq
  import gates7_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             id_q, id_d, last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [6:0]       gate_y;
  logic             pick, gnt;

  gates7_dataflow u_df (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .y_o (gate_y)
  );

  always_comb begin
    pick = 1'b0;
    case (op_q)
      OP_AND:  pick = gate_y[0];
      OP_OR:   pick = gate_y[1];
      OP_NOTA: pick = gate_y[2];
      OP_NAND: pick = gate_y[3];
      OP_NOR:  pick = gate_y[4];
      OP_XOR:  pick = gate_y[5];
      OP_XNOR: pick = gate_y[6];
      default: pick = 1'b0;
    endcase
  end

  // On a tie the requester that did not win last time is granted.
  assign gnt = (req0_valid && req1_valid) ? ~last_q : req1_valid;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    id_d       = id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = req0_valid && !gnt && !rst;
        req1_ready = req1_valid &&  gnt && !rst;
        if (req0_ready || req1_ready) begin
          op_d    = gnt ? req1_op : req0_op;
          a_d     = gnt ? req1_a  : req0_a;
          b_d     = gnt ? req1_b  : req0_b;
          id_d    = gnt;
          last_d  = gnt;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d = {pick, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign res_data  = res_q;
  assign res_id    = id_q;

endmodule

// File: doc/gates7_seq.md
# gates7_seq

Bit-serial sequencer and two-port arbiter for the shared single-bit logic unit `gates7_dataflow`. It accepts word-wide logic-operation requests from two requesters and grants them round-robin. It streams the operand bits LSB-first through the one gate unit, one bit per cycle, and assembles the selected function output into a result word. The result is returned to the winning requester over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a request.
- `req0_ready` out 1: requester 0 request is accepted this cycle.
- `req0_op` in 3: requester 0 function select.
- `req0_a` in `WIDTH`: requester 0 operand a.
- `req0_b` in `WIDTH`: requester 0 operand b.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same meaning for requester 1.
- `res_valid` out 1: result word is available.
- `res_ready` in 1: consumer takes the result.
- `res_data` out `WIDTH`: result word.
- `res_id` out 1: index of the requester that owns the result.
- `busy` out 1: high in RUN or DONE.

## Operation
- Op encoding:
  - 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
  - 7 is reserved: it produces an all-zero result with normal latency.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Combinational grant among the valid requesters.
  - With one requester valid, that one is granted.
  - With both valid, the requester other than `last_id` is granted.
  - Only the granted requester sees `ready`=1.
  - On valid&ready: capture op, a, b and id; set `last_id`=id; set `cnt`=0; go to RUN.
- RUN, one bit per cycle:
  - Drive a_sh[0] and b_sh[0] into `gates7_dataflow`.
  - Pick the output selected by op.
  - Shift the picked bit into the result from the MSB: `res`={bit, `res`[WIDTH-1:1]}.
  - Shift a_sh and b_sh right; increment `cnt`.
  - When `cnt`==WIDTH-1, go to DONE.
- DONE:
  - `res_valid`=1, with `res_data` and `res_id` held stable.
  - On `res_ready`=1, go to IDLE.
- Both `req*_ready` are 0 in RUN and DONE. No request is ever dropped; it waits with its valid held.
- Requester inputs are sampled only at the accept edge; later changes do not affect an operation in flight.

## Timing
- Accept edge T (IDLE→RUN). Bits are processed in cycles T+1..T+WIDTH.
- `res_valid` rises after edge T+WIDTH, so latency is WIDTH cycles from acceptance.
- A zero-wait consumer completes the handshake at edge T+WIDTH+1, which returns the FSM to IDLE.
- The earliest next accept is at edge T+WIDTH+2. Peak throughput is one operation per WIDTH+2 cycles.
- Reset values (any state, including mid-RUN or mid-DONE):
  - FSM goes to IDLE; the in-flight operation is discarded with no result.
  - `res_valid`=0, `res_data`=0, `res_id`=0, `busy`=0.
  - `last_id`=1, so requester 0 wins the first tie.
  - Both `req*_ready`=0 while `rst` is high.
- The `cnt` terminal compare is at WIDTH-1. `cnt` width is clog2(WIDTH)+1, so no wrap occurs for any legal WIDTH.
- A request valid in the same cycle as a DONE→IDLE transition is not accepted until the IDLE cycle that follows.

## Structure
- Shared package `gates7_pkg` holds:
  - Op code constants `OP_AND`..`OP_XNOR` and `OP_RSVD`.
  - FSM state encodings `ST_IDLE`, `ST_RUN`, `ST_DONE`.
- The only sub-module is the existing `gates7_dataflow`, instantiated once as the shared datapath.
- The arbiter, shifters, counter and FSM live in `gates7_seq` itself.

## Test plan
Benches use WIDTH=8.
- **Reset:** hold `rst` high for 2 cycles with both valids high -> both readies 0, `res_valid`=0, `res_data`=8'h00, `busy`=0. After release, req0 is granted first.
- **Single AND on req0:** a=8'hF0, b=8'h3C -> `res_data`=8'h30, `res_id`=0. `res_valid` rises exactly 8 cycles after the accept edge.
- **Op sweep on req1:** a=8'hA5, b=8'h0F -> AND 05, OR AF, NOT 5A, NAND FA, NOR 50, XOR AA, XNOR 55, op7 00. `res_id`=1 for every result.
- **Contention:** both valids held high for 4 operations with `res_ready`=1 -> grants and `res_id` sequence 0,1,0,1. Each operation's inputs are unchanged in its result.
- **Backpressure:** hold `res_ready`=0 for 5 cycles in DONE -> `res_valid`, `res_data` and `res_id` stay stable, and both readies stay 0. The result completes on the first cycle `res_ready`=1.
- **Reset mid-RUN:** assert `rst` 3 cycles into RUN -> no result is ever presented. The next request (XOR 8'hFF, 8'h0F) returns 8'hF0 with normal latency.
